// File: rtl/shutdown_sequencer.sv
// Power-rail sequencer: brings rails up in order after reset, and takes
// them down in reverse order on a long button press or a software request.
// Each rail step waits for that rail's power-good, with a timeout into FAULT.
module shutdown_sequencer #(
  parameter int NUM_RAILS  = 4,
  parameter int LONG_PRESS = 1000000,
  parameter int STEP_DELAY = 1000,
  parameter int PG_TIMEOUT = 50000,
  parameter int CNT_WIDTH  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_clean,
  input  logic                 sw_req,
  input  logic [NUM_RAILS-1:0] rail_pg,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 sys_on,
  output logic                 fault
);

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_UP    = 3'd1;
  localparam logic [2:0] S_ON    = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DOWN  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [1:0] P_SW   = 2'd0;
  localparam logic [1:0] P_WAIT = 2'd1;
  localparam logic [1:0] P_DLY  = 2'd2;

  localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;

  localparam logic [CNT_WIDTH-1:0] PRESS_LAST = CNT_WIDTH'(LONG_PRESS - 1);
  localparam logic [CNT_WIDTH-1:0] DLY_LAST   = CNT_WIDTH'(STEP_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST   = CNT_WIDTH'(PG_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_RAILS - 1);

  logic [2:0]           state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic                 btn_q;
  logic                 busy_q, busy_d;
  logic                 sys_on_q, sys_on_d;
  logic                 fault_q, fault_d;

  logic                 btn_rise;
  logic                 target;
  logic                 seq_last;
  logic [IDX_W-1:0]     idx_next;

  assign btn_rise = btn_clean & ~btn_q;
  // Rails are driven high while powering up, low while powering down.
  assign target   = (state_q == S_UP);
  assign seq_last = target ? (idx_q == IDX_LAST) : (idx_q == '0);
  assign idx_next = target ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);

  // State register; btn_q resets high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_UP;
      phase_q   <= P_SW;
      idx_q     <= '0;
      cnt_q     <= '0;
      rail_en_q <= '0;
      btn_q     <= 1'b1;
      busy_q    <= 1'b1;
      sys_on_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rail_en_q <= rail_en_d;
      btn_q     <= btn_clean;
      busy_q    <= busy_d;
      sys_on_q  <= sys_on_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state: sequencing steps, press timing and fault entry share one counter.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rail_en_d = rail_en_q;
    case (state_q)
      S_UP, S_DOWN: begin
        case (phase_q)
          P_SW: begin
            rail_en_d[idx_q] = target;
            cnt_d            = '0;
            phase_d          = P_WAIT;
          end
          P_WAIT: begin
            // Only the rail being stepped is watched; earlier rails may glitch.
            if (rail_pg[idx_q] == target) begin
              cnt_d   = '0;
              phase_d = P_DLY;
            end else if (cnt_q == TMO_LAST) begin
              state_d   = S_FAULT;
              rail_en_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          P_DLY: begin
            if (cnt_q == DLY_LAST) begin
              cnt_d = '0;
              if (seq_last) begin
                state_d = target ? S_ON : S_OFF;
                phase_d = P_SW;
              end else begin
                idx_d   = idx_next;
                phase_d = P_SW;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: phase_d = P_SW;
        endcase
      end
      S_ON: begin
        // Software request wins over a button edge in the same cycle.
        if (sw_req) begin
          state_d = S_DOWN;
          idx_d   = IDX_LAST;
          phase_d = P_SW;
          cnt_d   = '0;
        end else if (btn_rise) begin
          state_d = S_HOLD;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (sw_req || (btn_clean && cnt_q == PRESS_LAST)) begin
          state_d = S_DOWN;
          idx_d   = IDX_LAST;
          phase_d = P_SW;
          cnt_d   = '0;
        end else if (!btn_clean) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OFF: begin
        rail_en_d = '0;
        if (btn_rise) begin
          state_d = S_UP;
          idx_d   = '0;
          phase_d = P_SW;
          cnt_d   = '0;
        end
      end
      S_FAULT: rail_en_d = '0;
      // Unused encodings are treated as a fault with all rails dropped.
      default: begin
        state_d   = S_FAULT;
        rail_en_d = '0;
      end
    endcase
  end

  // Status flags decoded from the next state so they register alongside it.
  always_comb begin
    busy_d   = (state_d == S_UP) || (state_d == S_DOWN);
    sys_on_d = (state_d == S_ON) || (state_d == S_HOLD);
    fault_d  = (state_d == S_FAULT);
  end

  assign rail_en = rail_en_q;
  assign state   = state_q;
  assign busy    = busy_q;
  assign sys_on  = sys_on_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_shutdown_sequencer.sv
// Scoreboard bench: stimulus pushes expected (state, rail_en, gap) events,
// a negedge monitor pops one each time the DUT's state or rail_en changes.
module tb_shutdown_sequencer;

  localparam int NR = 3;
  localparam logic [2:0] OFF = 3'd0, UP = 3'd1, ON = 3'd2, HOLD = 3'd3,
                         DOWN = 3'd4, FLT = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_clean = 1'b0;
  logic          sw_req = 1'b0;
  logic [NR-1:0] rail_pg = '0;
  logic [NR-1:0] kill = '0;
  logic [NR-1:0] rail_en;
  logic [2:0]    state;
  logic          busy, sys_on, fault;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]    st;
    logic [NR-1:0] en;
    int            gap;   // cycles since previous change; -1 = unchecked
  } exp_t;
  exp_t q[$];

  shutdown_sequencer #(
    .NUM_RAILS(NR), .LONG_PRESS(10), .STEP_DELAY(4), .PG_TIMEOUT(8), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_clean(btn_clean), .sw_req(sw_req),
    .rail_pg(rail_pg), .rail_en(rail_en), .state(state),
    .busy(busy), .sys_on(sys_on), .fault(fault)
  );

  always #5 clk = ~clk;

  // Rail model: power-good follows the enable one register later, unless killed.
  always @(posedge clk) rail_pg <= rail_en & ~kill;

  task automatic ev(input logic [2:0] s, input logic [NR-1:0] e, input int g);
    q.push_back('{st: s, en: e, gap: g});
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc);
    int n = 0;
    while (state !== s && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== s) begin
      failures++;
      $display("FAIL wait_state got=%0d want=%0d", state, s);
    end
  endtask

  task automatic wait_en(input logic [NR-1:0] e, input int maxc);
    int n = 0;
    while (rail_en !== e && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rail_en !== e) begin
      failures++;
      $display("FAIL wait_rail_en got=%b want=%b", rail_en, e);
    end
  endtask

  task automatic push_up_seq();
    ev(UP, 3'b001, -1); ev(UP, 3'b011, 7); ev(UP, 3'b111, 7); ev(ON, 3'b111, 6);
  endtask

  task automatic push_down_seq(input int first_gap);
    ev(DOWN, 3'b011, first_gap); ev(DOWN, 3'b001, 7);
    ev(DOWN, 3'b000, 7); ev(OFF, 3'b000, 6);
  endtask

  // Monitor: one scoreboard pop per observed change of {state, rail_en}.
  initial begin
    logic [5:0] prev, cur;
    int cyc, last;
    exp_t e;
    logic xb, xs, xf;
    prev = 'x; cyc = 0; last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {state, rail_en};
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change state=%0d rail_en=%b cyc=%0d", state, rail_en, cyc);
        end else begin
          e  = q.pop_front();
          xb = (e.st == UP) || (e.st == DOWN);
          xs = (e.st == ON) || (e.st == HOLD);
          xf = (e.st == FLT);
          if (state !== e.st || rail_en !== e.en || (e.gap >= 0 && cyc - last != e.gap) ||
              busy !== xb || sys_on !== xs || fault !== xf) begin
            failures++;
            $display("FAIL event got st=%0d en=%b gap=%0d b/s/f=%b%b%b want st=%0d en=%b gap=%0d b/s/f=%b%b%b",
                     state, rail_en, cyc - last, busy, sys_on, fault,
                     e.st, e.en, e.gap, xb, xs, xf);
          end
        end
        last = cyc;
      end
      prev = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and power-up
    ev(UP, 3'b000, -1);
    push_up_seq();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_state(ON, 100);

    // Short press: nine high cycles, back to ON
    ev(HOLD, 3'b111, -1); ev(ON, 3'b111, 9);
    btn_clean = 1'b1;
    repeat (9) @(negedge clk);
    btn_clean = 1'b0;
    repeat (3) @(negedge clk);

    // Long press: ten high cycles, power down, held button must not restart
    ev(HOLD, 3'b111, -1); ev(DOWN, 3'b111, 9);
    push_down_seq(1);
    btn_clean = 1'b1;
    wait_state(OFF, 100);
    repeat (5) @(negedge clk);
    btn_clean = 1'b0;
    repeat (2) @(negedge clk);
    ev(UP, 3'b000, -1); ev(UP, 3'b001, 1); ev(UP, 3'b011, 7);
    ev(UP, 3'b111, 7);  ev(ON, 3'b111, 6);
    btn_clean = 1'b1;
    @(negedge clk);
    btn_clean = 1'b0;
    wait_state(ON, 100);

    // sw_req in ON, then sw_req ignored in OFF
    ev(DOWN, 3'b111, -1);
    push_down_seq(1);
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    wait_state(OFF, 100);
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    repeat (3) @(negedge clk);
    ev(UP, 3'b000, -1); ev(UP, 3'b001, 1); ev(UP, 3'b011, 7);
    ev(UP, 3'b111, 7);  ev(ON, 3'b111, 6);
    btn_clean = 1'b1;
    @(negedge clk);
    btn_clean = 1'b0;
    wait_state(ON, 100);

    // sw_req coincident with button rise: straight to DOWN, no HOLD
    ev(DOWN, 3'b111, -1);
    push_down_seq(1);
    btn_clean = 1'b1;
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    wait_state(OFF, 100);
    btn_clean = 1'b0;
    repeat (2) @(negedge clk);

    // PG timeout on rail 1 during power-up, then inputs ignored in FAULT
    kill = 3'b010;
    ev(UP, 3'b000, -1); ev(UP, 3'b001, -1); ev(UP, 3'b011, 7); ev(FLT, 3'b000, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_state(FLT, 100);
    btn_clean = 1'b1;
    repeat (3) @(negedge clk);
    btn_clean = 1'b0;
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    btn_clean = 1'b1;
    @(negedge clk);
    btn_clean = 1'b0;
    repeat (5) @(negedge clk);

    // Recover with reset, power up, then reset mid-DOWN with button held
    kill = '0;
    ev(UP, 3'b000, -1);
    push_up_seq();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_state(ON, 100);
    ev(DOWN, 3'b111, -1); ev(DOWN, 3'b011, 1); ev(DOWN, 3'b001, 7);
    ev(UP, 3'b000, -1);
    ev(UP, 3'b001, 1); ev(UP, 3'b011, 7); ev(UP, 3'b111, 7); ev(ON, 3'b111, 6);
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    wait_en(3'b001, 100);
    rst = 1'b1;
    btn_clean = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_state(ON, 100);
    repeat (15) @(negedge clk);
    btn_clean = 1'b0;
    repeat (5) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain remaining=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
